// File: rtl/seg7_scan_driver_pkg.sv
// Shared definitions for the 7-segment scan driver: FSM states, blank code,
// and active-low segment patterns (bit0=a ... bit6=g).
package seg7_scan_driver_pkg;

  typedef enum logic {ST_DARK = 1'b0, ST_ON = 1'b1} state_t;

  localparam logic [6:0] SEG_OFF = 7'h7F;

  localparam logic [6:0] SEG_0 = 7'h40;
  localparam logic [6:0] SEG_1 = 7'h79;
  localparam logic [6:0] SEG_2 = 7'h24;
  localparam logic [6:0] SEG_3 = 7'h30;
  localparam logic [6:0] SEG_4 = 7'h19;
  localparam logic [6:0] SEG_5 = 7'h12;
  localparam logic [6:0] SEG_6 = 7'h02;
  localparam logic [6:0] SEG_7 = 7'h78;
  localparam logic [6:0] SEG_8 = 7'h00;
  localparam logic [6:0] SEG_9 = 7'h10;
  localparam logic [6:0] SEG_A = 7'h08;
  localparam logic [6:0] SEG_B = 7'h03;
  localparam logic [6:0] SEG_C = 7'h46;
  localparam logic [6:0] SEG_D = 7'h21;
  localparam logic [6:0] SEG_E = 7'h06;
  localparam logic [6:0] SEG_F = 7'h0E;

endpackage

// File: rtl/seg7_decode.sv
// Combinational hex nibble to active-low 7-segment pattern.
module seg7_decode
  import seg7_scan_driver_pkg::*;
(
  input  logic [3:0] nib,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_OFF;
    case (nib)
      4'h0: seg = SEG_0;
      4'h1: seg = SEG_1;
      4'h2: seg = SEG_2;
      4'h3: seg = SEG_3;
      4'h4: seg = SEG_4;
      4'h5: seg = SEG_5;
      4'h6: seg = SEG_6;
      4'h7: seg = SEG_7;
      4'h8: seg = SEG_8;
      4'h9: seg = SEG_9;
      4'hA: seg = SEG_A;
      4'hB: seg = SEG_B;
      4'hC: seg = SEG_C;
      4'hD: seg = SEG_D;
      4'hE: seg = SEG_E;
      4'hF: seg = SEG_F;
      default: seg = SEG_OFF;
    endcase
  end

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed common-anode 7-seg driver with frame-boundary double buffering.
// Define SEG7_LZB_EN to blank leading zero digits (digit 0 always shown).
module seg7_scan_driver
  import seg7_scan_driver_pkg::*;
#(
  parameter int DIGITS    = 4,
  parameter int SCAN_DIV  = 1000,
  parameter int BLANK_CYC = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   value,
  output logic [6:0]            seg,
  output logic [DIGITS-1:0]     an,
  output logic                  load_pending,
  output logic                  frame_done
);

  localparam int CMAX = (SCAN_DIV > BLANK_CYC) ? SCAN_DIV : BLANK_CYC;
  localparam int CW   = (CMAX > 1) ? $clog2(CMAX) : 1;
  localparam int IW   = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  state_t                   st, st_nxt;
  logic [CW-1:0]            cnt, cnt_nxt;
  logic [IW-1:0]            idx, idx_nxt;
  logic                     commit;
  logic                     show;
  logic [DIGITS-1:0][3:0]   disp, shadow;
  logic [6:0]               dec_seg;

  always_comb begin
    st_nxt  = st;
    cnt_nxt = cnt + 1'b1;
    idx_nxt = idx;
    commit  = 1'b0;
    case (st)
      ST_DARK: if (cnt == CW'(BLANK_CYC - 1)) begin
        st_nxt  = ST_ON;
        cnt_nxt = '0;
      end
      ST_ON: if (cnt == CW'(SCAN_DIV - 1)) begin
        st_nxt  = ST_DARK;
        cnt_nxt = '0;
        commit  = (idx == IW'(DIGITS - 1));
        idx_nxt = commit ? '0 : idx + 1'b1;
      end
      default: ;
    endcase
  end

  // Outputs are registered from next-state values so they line up with the state.
  seg7_decode u_dec (.nib(disp[idx_nxt]), .seg(dec_seg));

`ifdef SEG7_LZB_EN
  logic [DIGITS-1:0] lz;
  for (genvar i = 0; i < DIGITS; i++) begin : g_lz
    if (i == 0) begin : g_d0
      assign lz[i] = 1'b0;
    end else begin : g_dn
      assign lz[i] = (disp[DIGITS-1:i] == '0);
    end
  end
  assign show = ~lz[idx_nxt];
`else
  assign show = 1'b1;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      st           <= ST_DARK;
      cnt          <= '0;
      idx          <= '0;
      seg          <= SEG_OFF;
      an           <= '1;
      frame_done   <= 1'b0;
      load_pending <= 1'b0;
      shadow       <= '0;
      disp         <= '0;
    end else begin
      st         <= st_nxt;
      cnt        <= cnt_nxt;
      idx        <= idx_nxt;
      frame_done <= (st_nxt == ST_ON) && (idx_nxt == IW'(DIGITS - 1)) &&
                    (cnt_nxt == CW'(SCAN_DIV - 1));
      if (st_nxt == ST_ON && show) begin
        an  <= ~(DIGITS'(1) << idx_nxt);
        seg <= dec_seg;
      end else begin
        an  <= '1;
        seg <= SEG_OFF;
      end
      // A load on the commit cycle bypasses the shadow so the newest value wins.
      if (commit) begin
        if (load) begin
          disp   <= value;
          shadow <= value;
        end else if (load_pending) begin
          disp <= shadow;
        end
        load_pending <= 1'b0;
      end else if (load) begin
        shadow       <= value;
        load_pending <= 1'b1;
      end
    end
  end

endmodule
